// File: rtl/ex_pkg.sv
// Shared definitions for the decode and execute stages: operation codes,
// base opcodes and immediate extraction helpers.
package ex_pkg;

    localparam int XLEN_DEF = 32;

    // Operation codes carried from decode on the oh bus
    localparam logic [6:0] OH_LUI   = 7'd1;
    localparam logic [6:0] OH_JAL   = 7'd3;
    localparam logic [6:0] OH_BEQ   = 7'd5;
    localparam logic [6:0] OH_BNE   = 7'd6;
    localparam logic [6:0] OH_ADDI  = 7'd19;
    localparam logic [6:0] OH_SLTI  = 7'd20;
    localparam logic [6:0] OH_SLTIU = 7'd21;
    localparam logic [6:0] OH_SLLI  = 7'd25;
    localparam logic [6:0] OH_SRLI  = 7'd26;
    localparam logic [6:0] OH_SRAI  = 7'd27;
    localparam logic [6:0] OH_ADD   = 7'd28;
    localparam logic [6:0] OH_SUB   = 7'd29;

    // RV32I base opcodes (ins[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational execute datapath: evaluates one decoded operation and reports
// its result, whether it writes rd, whether it redirects, and the target.
module ex_alu
    import ex_pkg::*;
(
    input  logic [6:0]  oh,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] ins,
    input  logic [31:0] ins_addr,
    output logic [31:0] result,
    output logic        writes,
    output logic        taken,
    output logic [31:0] target,
    output logic        illegal
);

    // Opcode field is already folded into oh by the decoder.
    logic unused_ins;
    assign unused_ins = ^ins[6:0];

    // Per-operation result, write intent and redirect decision
    always_comb begin
        result  = '0;
        writes  = 1'b0;
        taken   = 1'b0;
        target  = ins_addr + imm_b(ins);
        illegal = 1'b0;
        case (oh)
            OH_LUI: begin
                result = {ins[31:12], 12'b0};
                writes = 1'b1;
            end
            OH_JAL: begin
                result = ins_addr + 32'd4;
                writes = 1'b1;
                taken  = 1'b1;
                target = ins_addr + imm_j(ins);
            end
            OH_BEQ:   taken = (op1 == op2);
            OH_BNE:   taken = (op1 != op2);
            OH_ADDI: begin
                result = op1 + op2;
                writes = 1'b1;
            end
            OH_SLTI: begin
                result = {31'b0, ($signed(op1) < $signed(imm_i(ins)))};
                writes = 1'b1;
            end
            OH_SLTIU: begin
                result = {31'b0, (op1 < imm_i(ins))};
                writes = 1'b1;
            end
            OH_SLLI: begin
                result = op1 << op2[4:0];
                writes = 1'b1;
            end
            OH_SRLI: begin
                result = op1 >> op2[4:0];
                writes = 1'b1;
            end
            OH_SRAI: begin
                result = 32'($signed(op1) >>> op2[4:0]);
                writes = 1'b1;
            end
            OH_ADD: begin
                result = op1 + op2;
                writes = 1'b1;
            end
            OH_SUB: begin
                result = op1 - op2;
                writes = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex.sv
// Execute stage: registers write-back and redirect requests and squashes the
// wrong-path slots that follow a taken branch or jump.
module ex
    import ex_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] ins_addr,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_addr,
    input  logic            rd_wen,
    input  logic [6:0]      oh,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_we,
    output logic            jump_en,
    output logic [XLEN-1:0] jump_addr,
    output logic            illegal
);

    localparam int SQ_W = (FLUSH_SLOTS < 1) ? 1 : $clog2(FLUSH_SLOTS + 1);

    logic [31:0]     alu_result;
    logic            alu_writes;
    logic            alu_taken;
    logic [31:0]     alu_target;
    logic            alu_illegal;

    logic [4:0]      wb_addr_q,   wb_addr_d;
    logic [XLEN-1:0] wb_data_q,   wb_data_d;
    logic            wb_we_q,     wb_we_d;
    logic            jump_en_q,   jump_en_d;
    logic [XLEN-1:0] jump_addr_q, jump_addr_d;
    logic            illegal_q,   illegal_d;
    logic [SQ_W-1:0] sq_q,        sq_d;
    logic            accept;

    ex_alu u_alu (
        .oh       (oh),
        .op1      (op1),
        .op2      (op2),
        .ins      (ins),
        .ins_addr (ins_addr),
        .result   (alu_result),
        .writes   (alu_writes),
        .taken    (alu_taken),
        .target   (alu_target),
        .illegal  (alu_illegal)
    );

    // While the squash counter is nonzero the incoming slot is wrong-path.
    assign accept = in_valid && !stall && (sq_q == '0);

    // Next-state for output registers and squash counter
    always_comb begin
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_we_d     = 1'b0;
        jump_en_d   = 1'b0;
        jump_addr_d = jump_addr_q;
        illegal_d   = 1'b0;
        sq_d        = sq_q;
        if ((sq_q != '0) && !stall) begin
            sq_d = sq_q - SQ_W'(1);
        end
        if (accept) begin
            wb_addr_d = rd_addr;
            wb_data_d = alu_result;
            if (alu_illegal) begin
                illegal_d = 1'b1;
            end else begin
                wb_we_d = alu_writes && rd_wen && (rd_addr != 5'd0);
                if (alu_taken) begin
                    jump_en_d   = 1'b1;
                    jump_addr_d = alu_target;
                    sq_d        = SQ_W'(FLUSH_SLOTS);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_we_q     <= 1'b0;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            illegal_q   <= 1'b0;
            sq_q        <= '0;
        end else begin
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_we_q     <= wb_we_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            illegal_q   <= illegal_d;
            sq_q        <= sq_d;
        end
    end

    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign wb_we     = wb_we_q;
    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage with hand-computed expectations.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ins = '0;
    logic [31:0] ins_addr = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wen = 1'b0;
    logic [6:0]  oh = '0;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    ex dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .stall     (stall),
        .ins       (ins),
        .ins_addr  (ins_addr),
        .op1       (op1),
        .op2       (op2),
        .rd_addr   (rd_addr),
        .rd_wen    (rd_wen),
        .oh        (oh),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [6:0] o,
                         input logic [31:0] i, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
        in_valid = v; stall = s; oh = o; ins = i; ins_addr = pc;
        op1 = a; op2 = b; rd_addr = rd; rd_wen = we;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb_addr"},   32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"},   wb_data, 32'd0);
        chk({tag, "_wb_we"},     32'(wb_we), 32'd0);
        chk({tag, "_jump_en"},   32'(jump_en), 32'd0);
        chk({tag, "_jump_addr"}, jump_addr, 32'd0);
        chk({tag, "_illegal"},   32'(illegal), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        chk_zero("rst");
        rst_n = 1'b1;

        // ADDI 5 + (-3)
        drive(1, 0, OH_ADDI, 32'h0, 32'h0, 32'h5, 32'hFFFF_FFFD, 5'd3, 1);
        tick();
        chk("addi_we", 32'(wb_we), 32'd1);
        chk("addi_addr", 32'(wb_addr), 32'd3);
        chk("addi_data", wb_data, 32'd2);
        chk("addi_jump", 32'(jump_en), 32'd0);
        chk("addi_ill", 32'(illegal), 32'd0);

        // ADD to x0 never writes
        drive(1, 0, OH_ADD, 32'h0, 32'h0, 32'd7, 32'd9, 5'd0, 1);
        tick();
        chk("add_x0_we", 32'(wb_we), 32'd0);

        drive(1, 0, OH_SUB, 32'h0, 32'h0, 32'd0, 32'd1, 5'd4, 1);
        tick();
        chk("sub_we", 32'(wb_we), 32'd1);
        chk("sub_data", wb_data, 32'hFFFF_FFFF);

        drive(1, 0, OH_SRAI, 32'h0, 32'h0, 32'h8000_0000, 32'd31, 5'd5, 1);
        tick();
        chk("srai_data", wb_data, 32'hFFFF_FFFF);
        drive(1, 0, OH_SRLI, 32'h0, 32'h0, 32'h8000_0000, 32'd31, 5'd5, 1);
        tick();
        chk("srli_data", wb_data, 32'h0000_0001);

        drive(1, 0, OH_SLLI, 32'h0, 32'h0, 32'h0000_0003, 32'd4, 5'd5, 1);
        tick();
        chk("slli_data", wb_data, 32'h0000_0030);

        // -1 < 1 signed, but 0xFFFFFFFF >= 1 unsigned
        drive(1, 0, OH_SLTI, 32'h0010_0013, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd6, 1);
        tick();
        chk("slti_data", wb_data, 32'd1);
        drive(1, 0, OH_SLTIU, 32'h0010_0013, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd6, 1);
        tick();
        chk("sltiu_data", wb_data, 32'd0);

        drive(1, 0, OH_LUI, 32'h1234_50B7, 32'h0, 32'h0, 32'h0, 5'd1, 1);
        tick();
        chk("lui_data", wb_data, 32'h1234_5000);

        // Stalled bundle is not consumed; data holds
        drive(1, 1, OH_ADDI, 32'h0, 32'h0, 32'd1, 32'd1, 5'd2, 1);
        tick();
        chk("stall_we", 32'(wb_we), 32'd0);
        chk("stall_data", wb_data, 32'h1234_5000);

        // BNE not taken: no redirect, next bundle accepted at once
        drive(1, 0, OH_BNE, 32'hFE00_0CE3, 32'h100, 32'd5, 32'd5, 5'd0, 0);
        tick();
        chk("bne_nt_jump", 32'(jump_en), 32'd0);
        chk("bne_nt_we", 32'(wb_we), 32'd0);
        drive(1, 0, OH_ADDI, 32'h0, 32'h0, 32'd10, 32'd1, 5'd8, 1);
        tick();
        chk("after_bne_we", 32'(wb_we), 32'd1);
        chk("after_bne_data", wb_data, 32'd11);

        // BEQ taken, imm -8 at 0x100
        drive(1, 0, OH_BEQ, 32'hFE00_0CE3, 32'h100, 32'd5, 32'd5, 5'd0, 0);
        tick();
        chk("beq_jump", 32'(jump_en), 32'd1);
        chk("beq_target", jump_addr, 32'h0000_00F8);
        chk("beq_we", 32'(wb_we), 32'd0);
        drive(1, 0, OH_ADDI, 32'h0, 32'h0, 32'd1, 32'd1, 5'd7, 1);
        tick();
        chk("beq_sq1_we", 32'(wb_we), 32'd0);
        chk("beq_pulse", 32'(jump_en), 32'd0);
        chk("beq_hold", jump_addr, 32'h0000_00F8);
        tick();
        chk("beq_sq2_we", 32'(wb_we), 32'd0);
        tick();
        chk("beq_post_we", 32'(wb_we), 32'd1);
        chk("beq_post_data", wb_data, 32'd2);

        // JAL at 0x20, rd=1, imm 0x40, then a stalled cycle
        drive(1, 0, OH_JAL, 32'h0400_00EF, 32'h20, 32'h0, 32'h0, 5'd1, 1);
        tick();
        chk("jal_we", 32'(wb_we), 32'd1);
        chk("jal_addr", 32'(wb_addr), 32'd1);
        chk("jal_data", wb_data, 32'h0000_0024);
        chk("jal_jump", 32'(jump_en), 32'd1);
        chk("jal_target", jump_addr, 32'h0000_0060);
        drive(1, 1, OH_ADDI, 32'h0, 32'h0, 32'd3, 32'd3, 5'd9, 1);
        tick();
        chk("jal_stall_we", 32'(wb_we), 32'd0);
        chk("jal_stall_jump", 32'(jump_en), 32'd0);
        stall = 1'b0;
        tick();
        chk("jal_sq1_we", 32'(wb_we), 32'd0);
        tick();
        chk("jal_sq2_we", 32'(wb_we), 32'd0);
        tick();
        chk("jal_post_we", 32'(wb_we), 32'd1);
        chk("jal_post_data", wb_data, 32'd6);

        // Unsupported oh
        drive(1, 0, 7'h7F, 32'h0, 32'h0, 32'd1, 32'd1, 5'd9, 1);
        tick();
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_we", 32'(wb_we), 32'd0);
        chk("ill_jump", 32'(jump_en), 32'd0);
        drive(0, 0, OH_ADDI, 32'h0, 32'h0, 32'd1, 32'd1, 5'd9, 1);
        tick();
        chk("ill_once", 32'(illegal), 32'd0);
        chk("idle_we", 32'(wb_we), 32'd0);

        // Reset in the middle of a squash
        drive(1, 0, OH_BEQ, 32'hFE00_0CE3, 32'h100, 32'd5, 32'd5, 5'd0, 0);
        tick();
        chk("rst_sq_jump", 32'(jump_en), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        #2;
        rst_n = 1'b1;
        drive(1, 0, OH_ADDI, 32'h0, 32'h0, 32'd20, 32'd22, 5'd12, 1);
        tick();
        chk("rst_post_we", 32'(wb_we), 32'd1);
        chk("rst_post_addr", 32'(wb_addr), 32'd12);
        chk("rst_post_data", wb_data, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the RV32I core. Consumes the decoded instruction bundle driven by the decoder through the id_ex register and evaluates the one-hot-indexed operation (`oh`). Registers the write-back request toward the register file, and registers branch/jump redirects toward fetch. Owns wrong-path squashing after a taken control transfer.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `FLUSH_SLOTS`, 2: number of wrong-path slots squashed after a taken branch or jump.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded bundle on the inputs is valid this cycle.
- `stall`  in  1  hold from control; when high the bundle is not consumed.
- `ins`  in  32  raw instruction word.
- `ins_addr`  in  32  PC of `ins`.
- `op1`, `op2`  in  32 each  operands from decode.
- `rd_addr`  in  5  destination register.
- `rd_wen`  in  1  destination write requested.
- `oh`  in  7  operation code from decode.
- `wb_addr`  out  5  register-file write address (registered).
- `wb_data`  out  32  register-file write data (registered).
- `wb_we`  out  1  register-file write enable (registered).
- `jump_en`  out  1  one-cycle redirect pulse (registered).
- `jump_addr`  out  32  redirect target, valid while `jump_en` is high.
- `illegal`  out  1  one-cycle pulse: accepted bundle had an unsupported `oh`.

## Operation
- A bundle is accepted in a cycle when `in_valid` is 1, `stall` is 0, and the squash counter is 0.
- Operations, by `oh`. All arithmetic is modulo 2^32.
  - LUI (1): result = {ins[31:12], 12'b0}.
  - JAL (3): result = ins_addr + 4; taken, target = ins_addr + sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
  - BEQ (5) / BNE (6): compare op1 with op2; taken on equal or not-equal respectively. Target = ins_addr + sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}). No write.
  - ADDI (19): result = op1 + op2.
  - SLTI (20) / SLTIU (21): result = 1 if op1 < sext(ins[31:20]), signed or unsigned respectively; else 0.
  - SLLI (25) / SRLI (26) / SRAI (27): shift op1 by op2[4:0]; SRAI is arithmetic.
  - ADD (28) / SUB (29): result = op1 ± op2.
- Write-back: on acceptance, `wb_we` is set to `rd_wen` AND (rd_addr ≠ 0), with `wb_addr` and `wb_data` captured. Otherwise `wb_we` is 0 next cycle; `wb_addr` and `wb_data` hold their values.
- Unsupported `oh` when accepted: no write, no jump, `illegal` = 1 for one cycle.
- Squash counter (0..FLUSH_SLOTS):
  - Loaded with FLUSH_SLOTS on acceptance of a taken branch or jump.
  - Decrements by 1 every cycle it is nonzero and `stall` is 0; frozen while `stall` is 1.
  - While nonzero, inputs are ignored: no write, no jump, no `illegal`.
- A JAL both writes rd and redirects, in the same cycle.

## Timing
- Reset values: `wb_addr` = 0, `wb_data` = 0, `wb_we` = 0, `jump_en` = 0, `jump_addr` = 0, `illegal` = 0, squash counter = 0.
- Latency is one cycle. A bundle accepted in cycle N appears on `wb_*`, `jump_*`, and `illegal` after edge N+1.
- `jump_en` is a single-cycle pulse. `jump_addr` holds its last value when `jump_en` is 0.
- Stall in the cycle after a redirect: the squash count does not move. Wrong-path slots are counted only in non-stalled cycles.
- A taken branch is never accepted while the counter is nonzero, so there is no back-to-back redirect.
- Reset asserted mid-squash clears the counter. The first valid bundle after reset release is accepted.

## Structure
- Shared package (also imported by the decoder) holds:
  - `oh` codes: OH_LUI = 1, OH_JAL = 3, OH_BEQ = 5, OH_BNE = 6, OH_ADDI = 19, OH_SLTI = 20, OH_SLTIU = 21, OH_SLLI = 25, OH_SRLI = 26, OH_SRAI = 27, OH_ADD = 28, OH_SUB = 29.
  - Opcode constants.
  - Immediate-extraction functions for the I, B, and J formats.
- One combinational sub-module, `ex_alu`: takes `oh`, op1, op2, `ins`, and `ins_addr`; returns result, taken, target, and illegal.
- The `ex` top holds the output registers and the squash counter.

## Test plan
- ADDI: op1 = 0x0000_0005, op2 = 0xFFFF_FFFD, rd = 3 -> next cycle wb_we = 1, wb_addr = 3, wb_data = 0x0000_0002.
- ADD with rd = 0, op1 = 7, op2 = 9 -> wb_we = 0; SUB with op1 = 0, op2 = 1, rd = 4 -> wb_data = 0xFFFF_FFFF.
- SRAI: op1 = 0x8000_0000, op2 = 31 -> wb_data = 0xFFFF_FFFF. SRLI with the same operands -> 0x0000_0001.
- BEQ taken: ins_addr = 0x100, op1 = op2 = 5, B-imm = -8. Then two valid ADDIs. -> jump_en pulse with jump_addr = 0xF8; both ADDIs produce wb_we = 0; a third ADDI writes.
- JAL at 0x20, rd = 1, J-imm = 0x40, with stall asserted in the following cycle. -> wb_data = 0x24 and jump_addr = 0x60; the squash lasts 2 non-stalled cycles.
- Unsupported oh = 0x7F accepted -> illegal pulses once, wb_we = 0. Reset asserted mid-squash -> all outputs 0 and the next ADDI writes.
